card_dealer: RTL

Upstream stage of the hand comparator: deals two five-card hands of distinct card codes (0..51) from one 52-card deck per request. Uses a free-running 16-bit LFSR with rejection sampling. Presents ten held card outputs plus a valid flag, which feed the comparator's a1..a5 / b1..b5 inputs directly.

---
 rtl/card_dealer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// card_dealer: deals two five-card hands of distinct codes (0..NUM_CARDS-1)
// from a single deck per request, using a free-running 16-bit Galois LFSR
// with rejection sampling. Slots fill in order a1..a5, b1..b5.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned NUM_CARDS = 52
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       deal,
  output logic [5:0] a1,
  output logic [5:0] a2,
  output logic [5:0] a3,
  output logic [5:0] a4,
  output logic [5:0] a5,
  output logic [5:0] b1,
  output logic [5:0] b2,
  output logic [5:0] b3,
  output logic [5:0] b4,
  output logic [5:0] b5,
  output logic       valid,
  output logic       busy,
  output logic [3:0] dealt_cnt
);

  // An all-zero seed would lock the LFSR; fall back to 1.
  localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] Taps     = 16'hB400;
  localparam int unsigned NumSlots = 10;

  typedef enum logic [1:0] {StIdle, StClear, StDraw, StDone} state_e;

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_CARDS-1:0] used_q, used_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [5:0]           slot_q [NumSlots];
  logic [5:0]           slot_d [NumSlots];
  logic                 valid_q, valid_d;

  logic [5:0]  cand;
  logic [63:0] used_ext;
  logic        in_range;
  logic        accept;

  // Candidate comes from the pre-update LFSR value; out-of-deck codes never index used_q.
  assign cand     = lfsr_q[5:0];
  assign used_ext = 64'(used_q);
  assign in_range = (32'(cand) < NUM_CARDS);
  assign accept   = in_range && !used_ext[cand];

  // LFSR advances every cycle regardless of state.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Taps : 16'h0000);
  end

  // Next-state logic: deal sequencing, used-mask bookkeeping and slot fill.
  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (deal) state_d = StClear;
      end
      StClear: begin
        used_d  = '0;
        cnt_d   = 4'd0;
        valid_d = 1'b0;
        state_d = StDraw;
      end
      StDraw: begin
        if (accept) begin
          used_d[cand] = 1'b1;
          for (int i = 0; i < NumSlots; i++) begin
            if (cnt_q == 4'(i)) slot_d[i] = cand;
          end
          cnt_d = cnt_q + 4'd1;
          // Final card and valid land on the same edge.
          if (cnt_q == 4'(NumSlots - 1)) begin
            state_d = StDone;
            valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (deal) begin
          state_d = StClear;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      used_q  <= '0;
      cnt_q   <= 4'd0;
      slot_q  <= '{default: '0};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      used_q  <= used_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign a1        = slot_q[0];
  assign a2        = slot_q[1];
  assign a3        = slot_q[2];
  assign a4        = slot_q[3];
  assign a5        = slot_q[4];
  assign b1        = slot_q[5];
  assign b2        = slot_q[6];
  assign b3        = slot_q[7];
  assign b4        = slot_q[8];
  assign b5        = slot_q[9];
  assign valid     = valid_q;
  assign busy      = (state_q == StClear) || (state_q == StDraw);
  assign dealt_cnt = cnt_q;

endmodule
